// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and constants for the divider arbiter.
// Holds the FSM encoding, datapath width and default error quotient.
package div_arb_pkg;

    localparam int DIV_W = 32;

    localparam logic [DIV_W-1:0] ERR_QUOT_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DELIVER
    } div_arb_state_t;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches upward from last_grant+1 and wraps; last_grant itself is lowest.
module rr_pick #(
    parameter int NUM_REQ = 3,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_grant_i,
    output logic               valid_o,
    output logic [IW-1:0]      winner_o
);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one external 32-bit divider among NUM_REQ requesters.
// Sequences reset/start/wait/deliver; resolves divide-by-zero and hangs locally.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int               NUM_REQ  = 3,
    parameter int               TIMEOUT  = 40,
    parameter logic [DIV_W-1:0] ERR_QUOT = ERR_QUOT_DEF
) (
    input  logic                     clk_div,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [DIV_W*NUM_REQ-1:0] dividend_flat,
    input  logic [DIV_W*NUM_REQ-1:0] divisor_flat,
    output logic [NUM_REQ-1:0]       ack,
    output logic [DIV_W-1:0]         res_quotient,
    output logic [DIV_W-1:0]         res_remainder,
    output logic                     res_err,
    output logic                     busy,
    output logic                     div_reset,
    output logic                     div_start,
    output logic [DIV_W-1:0]         div_dividend,
    output logic [DIV_W-1:0]         div_divisor,
    input  logic [DIV_W-1:0]         div_quotient,
    input  logic [DIV_W-1:0]         div_remainder,
    input  logic                     div_done
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    div_arb_state_t   state_q, state_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] dvd_q, dvd_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [DIV_W-1:0] quot_q, quot_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    logic             pick_valid;
    logic [IW-1:0]    pick_winner;

    logic [DIV_W-1:0] dvd_a [NUM_REQ];
    logic [DIV_W-1:0] dvs_a [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    // Split the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            dvd_a[i] = dividend_flat[i*DIV_W +: DIV_W];
            dvs_a[i] = divisor_flat[i*DIV_W +: DIV_W];
        end
    end

    // Next-state logic: grant, launch, run with timeout, deliver.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cnt_d        = cnt_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        err_d        = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_id_d = pick_winner;
                    dvd_d      = dvd_a[pick_winner];
                    dvs_d      = dvs_a[pick_winner];
                    if (dvs_a[pick_winner] == '0) begin
                        quot_d  = ERR_QUOT;
                        rem_d   = dvd_a[pick_winner];
                        err_d   = 1'b1;
                        state_d = ST_DELIVER;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (div_done) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    err_d   = 1'b0;
                    state_d = ST_DELIVER;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    quot_d  = ERR_QUOT;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_div) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cnt_q        <= cnt_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
        end
    end

    // Output decode; the divider is held in reset outside RUN.
    always_comb begin
        ack = '0;
        if (state_q == ST_DELIVER) begin
            ack[grant_id_q] = 1'b1;
        end
        busy      = (state_q != ST_IDLE);
        div_start = (state_q == ST_RUN);
        div_reset = (state_q != ST_RUN);
    end

    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign res_quotient  = quot_q;
    assign res_remainder = rem_q;
    assign res_err       = err_q;

endmodule
